// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared parameters for integer/float conversion units
package fpu_pkg;

   localparam int ITOF_LAT   = 3;
   localparam int ITOF_DEPTH = 8;
   localparam int ITOF_TAG_W = 5;
   localparam int FP32_W     = 32;

   // Occupancy counters must be able to represent a completely full buffer.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/itof_rfifo.sv
// rtl/itof_rfifo.sv - result FIFO holding {float result, tag} for itof_seq
module itof_rfifo
   import fpu_pkg::*;
#(
   parameter int DW    = FP32_W + ITOF_TAG_W,
   parameter int DEPTH = ITOF_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [DW-1:0]          push_data_i,
   input  logic                   pop_i,
   output logic [DW-1:0]          head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_pop;

   // A pop against an empty buffer is ignored so the count cannot wrap.
   assign do_pop  = pop_i && (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Credit logic upstream must make a push into a full buffer impossible.
   always_ff @(posedge clk) begin
      if (!reset) assert (!(push_i && (count_q == (AW+1)'(DEPTH))));
   end

endmodule

// File: rtl/itof_seq.sv
// rtl/itof_seq.sv - sequencer around an external int-to-float stage with tag tracking and result buffering
module itof_seq
   import fpu_pkg::*;
#(
   parameter int LAT   = ITOF_LAT,
   parameter int DEPTH = ITOF_DEPTH,
   parameter int TAG_W = ITOF_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      cvt_op,
   input  logic [31:0]      cvt_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int CW = fifo_cnt_w(DEPTH);
   localparam int DW = FP32_W + TAG_W;

   // Stage i mirrors the itof stage: stage LAT lines up with cvt_result.
   logic [LAT:0]            vld_q, vld_d;
   logic [LAT:0][TAG_W-1:0] tag_q, tag_d;

   logic          accept;
   logic          pop;
   logic          push;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   pipe_cnt;
   logic [CW:0]   credit_used;
   logic [DW-1:0] head;

   // The itof stage samples every edge; only accepted samples are tracked.
   assign cvt_op    = in_data;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign push      = vld_q[LAT];
   assign out_valid = (fifo_count != '0);
   assign busy      = (|vld_q) || out_valid;
   assign out_data  = head[DW-1:TAG_W];
   assign out_tag   = head[TAG_W-1:0];

   // Tracking pipe next state: stage 0 takes the new request, others shift.
   always_comb begin
      vld_d = {vld_q[LAT-1:0], accept};
      tag_d = {tag_q[LAT-1:0], in_tag};
   end

   // Tracking pipe registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         tag_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end

   // Every in-flight op owns a FIFO slot, so new work is admitted only while
   // buffered plus in-flight results (less the one leaving now) fit.
   always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i <= LAT; i++) pipe_cnt = pipe_cnt + (CW+1)'(vld_q[i]);
      credit_used = {1'b0, fifo_count} + pipe_cnt - (CW+1)'(pop);
      in_ready    = !reset && (credit_used < (CW+1)'(DEPTH));
   end

   itof_rfifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_rfifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i ({cvt_result, tag_q[LAT]}),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_itof_seq.sv
// tb/tb_itof_seq.sv - self-checking bench for itof_seq with a behavioural itof stage
module tb_itof_seq;

   localparam int LAT   = 3;
   localparam int DEPTH = 8;
   localparam int TAG_W = 5;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      cvt_op;
   logic [31:0]      cvt_result;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   itof_seq #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_tag     (in_tag),
      .cvt_op     (cvt_op),
      .cvt_result (cvt_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural int-to-float, round to nearest even.
   function automatic logic [31:0] itof(input logic [31:0] x);
      logic        s;
      logic [31:0] a;
      logic [31:0] rem;
      logic [31:0] half;
      logic [24:0] mant;
      logic [7:0]  e;
      int          p;
      int          sh;
      if (x == 32'd0) return 32'd0;
      s = x[31];
      a = s ? (~x + 32'd1) : x;
      p = 31;
      while (a[p] == 1'b0) p--;
      if (p <= 23) begin
         mant = 25'(a << (23 - p));
      end else begin
         sh   = p - 23;
         mant = 25'(a >> sh);
         rem  = a & ((32'd1 << sh) - 32'd1);
         half = 32'd1 << (sh - 1);
         if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
      end
      e = 8'(127 + p);
      if (mant[24]) begin
         mant = mant >> 1;
         e    = e + 8'd1;
      end
      return {s, e, mant[22:0]};
   endfunction

   // External itof stage: op sampled at edge k, result visible after edge k+LAT.
   logic [31:0] stg [0:LAT];
   always @(posedge clk) begin
      stg[0] <= itof(cvt_op);
      for (int i = 1; i <= LAT; i++) stg[i] <= stg[i-1];
   end
   assign cvt_result = stg[LAT];

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   typedef struct {
      logic [31:0] din;
      logic [31:0] dout;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[12];
   int          tests = 0;
   int          fails = 0;
   int          n_acc = 0;
   int          n_pop = 0;
   logic [31:0] cur_exp;
   logic        last_in_ready;
   logic        last_out_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called 1ns after an edge with inputs set; samples, scores, advances one edge.
   task automatic step();
      exp_t e;
      #1;
      last_in_ready  = in_ready;
      last_out_valid = out_valid;
      if (in_valid && in_ready) begin
         exp_q.push_back({cur_exp, in_tag});
         n_acc++;
      end
      if (out_valid && out_ready) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            check("unexpected_out", out_data, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", 32'(out_tag), 32'(e.tag));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] x, input logic [TAG_W-1:0] t);
      in_valid = v;
      in_data  = d;
      cur_exp  = x;
      in_tag   = t;
   endtask

   task automatic drain();
      int n;
      n = 0;
      drive(1'b0, 32'd0, 32'd0, '0);
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         step();
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 32'd0, 32'd0, '0);
      out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("in_ready_in_reset", 32'(in_ready), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      #1;
   endtask

   initial begin
      int edges;
      int acc0;
      int spurious;
      logic [31:0] v;

      vecs[0]  = '{32'd1,          32'h3F80_0000};
      vecs[1]  = '{32'hFFFF_FFFF,  32'hBF80_0000};
      vecs[2]  = '{32'hFFFF_FFFE,  32'hC000_0000};
      vecs[3]  = '{32'd100,        32'h42C8_0000};
      vecs[4]  = '{32'd0,          32'h0000_0000};
      vecs[5]  = '{32'd7,          32'h40E0_0000};
      vecs[6]  = '{32'hFFFF_FF9C,  32'hC2C8_0000};
      vecs[7]  = '{32'h7FFF_FFFF,  32'h4F00_0000};
      vecs[8]  = '{32'h8000_0000,  32'hCF00_0000};
      vecs[9]  = '{32'h0100_0001,  32'h4B80_0000};
      vecs[10] = '{32'h0100_0003,  32'h4B80_0002};
      vecs[11] = '{32'h00FF_FFFF,  32'h4B7F_FFFF};

      // Reset state.
      do_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);

      // Single op latency: accept at edge k, out_valid after edge k+LAT+1.
      out_ready = 1'b1;
      drive(1'b1, 32'd1, 32'h3F80_0000, 5'd3);
      step();
      drive(1'b0, 32'd0, 32'd0, '0);
      check("single_busy", 32'(busy), 32'd1);
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("single_latency", 32'(edges), 32'(LAT + 1));
      drain();

      // Table vectors back to back with out_ready high; in_ready must never drop.
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, vecs[i].din, vecs[i].dout, TAG_W'(i));
         step();
         check("tbl_in_ready", 32'(last_in_ready), 32'd1);
      end
      drain();
      check("tbl_pops", 32'(n_pop), 32'(n_acc));

      // Stall: exactly DEPTH accepted, then in_ready held low.
      do_reset();
      acc0 = n_acc;
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, TAG_W'(i));
         step();
      end
      check("stall_accepts", 32'(n_acc - acc0), 32'(DEPTH));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold_data", out_data, 32'h4F00_0000);
      check("stall_hold_tag", 32'(out_tag), 32'd0);

      // Full buffer released with a request waiting: pop and accept together,
      // then one request per cycle sustained.
      out_ready = 1'b1;
      drive(1'b1, 32'd100, 32'h42C8_0000, 5'd20);
      step();
      check("full_same_accept", 32'(last_in_ready), 32'd1);
      check("full_same_pop", 32'(last_out_valid), 32'd1);
      acc0 = n_acc;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'(i + 2), itof(32'(i + 2)), TAG_W'(21 + i));
         step();
      end
      check("throughput", 32'(n_acc - acc0), 32'd10);
      drain();
      check("stream_pops", 32'(n_pop), 32'(n_acc));

      // Reset with 3 in flight and 2 buffered discards everything.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = 32'(i + 1);
         drive(1'b1, v, itof(v), TAG_W'(i));
         step();
      end
      drive(1'b0, 32'd0, 32'd0, '0);
      step();
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_out_valid) spurious++;
      end
      check("no_stale", 32'(spurious), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
